antirrebote_switch: RTL

ANTIRREBOTE_SWITCH -- requirements
Module: antirrebote_switch

---
 rtl/antirrebote_switch_pkg.sv | 16 +
 rtl/sincronizador_2ff.sv | 27 ++
 rtl/antirrebote_switch.sv | 87 ++++++++
 3 files changed

// File: rtl/antirrebote_switch_pkg.sv
// Shared types and constants for the switch debouncer.
package antirrebote_switch_pkg;

    // Clocks a new switch value must hold: 10 ms at 100 MHz.
    localparam int unsigned CICLOS_ESTABLE_DEF = 1000000;

    // Number of board switches handled by the debouncer.
    localparam int unsigned AnchoSwitch = 4;

    // Debouncer FSM: idle/settled, or timing a candidate value.
    typedef enum logic {
        Estable  = 1'b0,
        Contando = 1'b1
    } estado_e;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, cleared by a synchronous reset.
module sincronizador_2ff #(
    parameter int unsigned Ancho = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Ancho-1:0] d_i,
    output logic [Ancho-1:0] q_o
);

    logic [Ancho-1:0] sync1_q;
    logic [Ancho-1:0] sync2_q;

    // Shift the raw input through two flops; only the second stage is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/antirrebote_switch.sv
// Switch debouncer: a new 4-bit switch value is accepted only after it has been
// seen unchanged for CICLOS_ESTABLE consecutive clocks past the synchronizer.
module antirrebote_switch
    import antirrebote_switch_pkg::*;
#(
    parameter int unsigned CICLOS_ESTABLE = CICLOS_ESTABLE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AnchoSwitch-1:0] switch_in,
    output logic [AnchoSwitch-1:0] switch_out,
    output logic                   cambio,
    output logic                   estable
);

    localparam int unsigned AnchoCont = $clog2(CICLOS_ESTABLE + 1);
    localparam logic [AnchoCont-1:0] ContMax = AnchoCont'(CICLOS_ESTABLE - 1);
    localparam logic [AnchoCont-1:0] ContUno = AnchoCont'(1);

    logic [AnchoSwitch-1:0] sync2;
    estado_e                estado_q;
    logic [AnchoSwitch-1:0] candidato_q;
    logic [AnchoCont-1:0]   contador_q;
    logic [AnchoSwitch-1:0] switch_out_q;
    logic                   cambio_q;

    sincronizador_2ff #(
        .Ancho (AnchoSwitch)
    ) u_sincronizador (
        .clk (clk),
        .rst (rst),
        .d_i (switch_in),
        .q_o (sync2)
    );

    // Debounce FSM: time a candidate, restart on a new value, drop it if the old value returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q     <= Estable;
            candidato_q  <= '0;
            contador_q   <= '0;
            switch_out_q <= '0;
            cambio_q     <= 1'b0;
        end else begin
            cambio_q <= 1'b0;
            case (estado_q)
                Estable: begin
                    if (sync2 != switch_out_q) begin
                        estado_q    <= Contando;
                        candidato_q <= sync2;
                        contador_q  <= ContUno;
                    end else begin
                        contador_q <= '0;
                    end
                end
                Contando: begin
                    // A return to the accepted value wins over everything else.
                    if (sync2 == switch_out_q) begin
                        estado_q   <= Estable;
                        contador_q <= '0;
                    end else if (sync2 == candidato_q) begin
                        if (contador_q == ContMax) begin
                            switch_out_q <= candidato_q;
                            cambio_q     <= 1'b1;
                            estado_q     <= Estable;
                            contador_q   <= '0;
                        end else begin
                            contador_q <= contador_q + ContUno;
                        end
                    end else begin
                        candidato_q <= sync2;
                        contador_q  <= ContUno;
                    end
                end
                default: begin
                    estado_q   <= Estable;
                    contador_q <= '0;
                end
            endcase
        end
    end

    assign switch_out = switch_out_q;
    assign cambio     = cambio_q;
    assign estable    = (estado_q == Estable);

endmodule
